// File: rtl/lzrw_group_packer.sv
// Groups literal/copy items GROUP at a time behind a GROUP-bit control word and
// streams each group as LZRW1 bytes (control bytes LSB first, then item bytes).
module lzrw_group_packer #(
   parameter int GROUP    = 16,
   parameter int LEN_W    = 4,
   parameter int OFFSET_W = 12,
   parameter int CNT_W    = 32
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_item_valid,
   output logic                o_item_ready,
   input  logic                i_item_is_copy,
   input  logic [7:0]          i_item_literal,
   input  logic [LEN_W-1:0]    i_item_length,
   input  logic [OFFSET_W-1:0] i_item_offset,
   input  logic                i_flush,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [7:0]          o_out_data,
   output logic                o_out_last,
   output logic                o_flush_done,
   output logic [CNT_W-1:0]    o_bytes_out,
   output logic [CNT_W-1:0]    o_items_in
);
   localparam int COPY_BYTES = (LEN_W + OFFSET_W) / 8;
   localparam int BUF        = GROUP * COPY_BYTES;
   localparam int CTRL_BYTES = GROUP / 8;
   localparam int PTR_W      = $clog2(BUF + 1);
   localparam int ICW        = $clog2(GROUP + 1);

   typedef enum logic [1:0] {S_COLLECT, S_EMIT_CTRL, S_EMIT_DATA, S_DONE} state_t;

   state_t                    r_state, w_state_nxt;
   logic [7:0]                r_buf [BUF];
   logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
   logic [ICW-1:0]            r_item_cnt;
   logic [GROUP-1:0]          r_ctrl;
   logic                      r_flush_pend, r_flushing;
   logic [CNT_W-1:0]          r_bytes_out, r_items_in;

   logic                      w_accept, w_xfer, w_flush_req, w_ctrl_last, w_data_last;
   logic [ICW-1:0]            w_cnt_next;
   logic [LEN_W+OFFSET_W-1:0] w_copy_word;
   logic [7:0]                w_buf_byte, w_ctrl_byte;

   assign w_accept    = (r_state == S_COLLECT) && i_item_valid;
   assign w_cnt_next  = r_item_cnt + ICW'(w_accept);
   assign w_flush_req = i_flush | r_flush_pend;
   assign w_xfer      = o_out_valid && i_out_ready;
   assign w_ctrl_last = (r_rd_ptr == PTR_W'(CTRL_BYTES - 1));
   assign w_data_last = ((r_rd_ptr + PTR_W'(1)) == r_wr_ptr);
   assign w_copy_word = {i_item_length, i_item_offset};

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_COLLECT;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: begin
            if (w_accept && (w_cnt_next == ICW'(GROUP)))
               w_state_nxt = S_EMIT_CTRL;
            else if (w_flush_req)
               w_state_nxt = (w_cnt_next != '0) ? S_EMIT_CTRL : S_DONE;
         end
         S_EMIT_CTRL: if (w_xfer && w_ctrl_last) w_state_nxt = S_EMIT_DATA;
         S_EMIT_DATA: if (w_xfer && w_data_last) w_state_nxt = r_flushing ? S_DONE : S_COLLECT;
         default:     w_state_nxt = S_DONE;
      endcase
   end

   // Byte muxes: rd_ptr indexes control bytes first, then the item buffer
   always_comb begin
      w_buf_byte  = 8'h00;
      w_ctrl_byte = 8'h00;
      for (int b = 0; b < BUF; b++)
         if (b == int'(r_rd_ptr)) w_buf_byte = r_buf[b];
      for (int k = 0; k < CTRL_BYTES; k++)
         if (k == int'(r_rd_ptr)) w_ctrl_byte = r_ctrl[k*8 +: 8];
   end

   // Output logic
   always_comb begin
      o_item_ready = (r_state == S_COLLECT);
      o_out_valid  = (r_state == S_EMIT_CTRL) || (r_state == S_EMIT_DATA);
      o_flush_done = (r_state == S_DONE);
      o_out_data   = 8'h00;
      o_out_last   = 1'b0;
      if (r_state == S_EMIT_CTRL) o_out_data = w_ctrl_byte;
      if (r_state == S_EMIT_DATA) begin
         o_out_data = w_buf_byte;
         o_out_last = r_flushing && w_data_last;
      end
   end

   assign o_bytes_out = r_bytes_out;
   assign o_items_in  = r_items_in;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_item_cnt   <= '0;
         r_ctrl       <= '0;
         r_flush_pend <= 1'b0;
         r_flushing   <= 1'b0;
         r_bytes_out  <= '0;
         r_items_in   <= '0;
      end else begin
         if (w_xfer) r_bytes_out <= r_bytes_out + CNT_W'(1);
         case (r_state)
            S_COLLECT: begin
               if (w_accept) begin
                  for (int g = 0; g < GROUP; g++)
                     if (g == int'(r_item_cnt)) r_ctrl[g] <= i_item_is_copy;
                  for (int b = 0; b < BUF; b++) begin
                     if (!i_item_is_copy && b == int'(r_wr_ptr)) r_buf[b] <= i_item_literal;
                     for (int k = 0; k < COPY_BYTES; k++)
                        if (i_item_is_copy && b == int'(r_wr_ptr) + k)
                           r_buf[b] <= w_copy_word[(COPY_BYTES-1-k)*8 +: 8];
                  end
                  r_wr_ptr   <= r_wr_ptr + (i_item_is_copy ? PTR_W'(COPY_BYTES) : PTR_W'(1));
                  r_item_cnt <= w_cnt_next;
                  r_items_in <= r_items_in + CNT_W'(1);
               end
               // A full group also consumes a flush request seen this cycle
               if (w_state_nxt != S_COLLECT) begin
                  r_flushing   <= w_flush_req;
                  r_flush_pend <= 1'b0;
                  r_rd_ptr     <= '0;
               end
            end
            S_EMIT_CTRL: begin
               if (i_flush) r_flush_pend <= 1'b1;
               if (w_xfer) r_rd_ptr <= w_ctrl_last ? '0 : r_rd_ptr + PTR_W'(1);
            end
            S_EMIT_DATA: begin
               if (i_flush) r_flush_pend <= 1'b1;
               if (w_xfer) begin
                  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                  if (w_data_last && !r_flushing) begin
                     r_ctrl     <= '0;
                     r_wr_ptr   <= '0;
                     r_rd_ptr   <= '0;
                     r_item_cnt <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lzrw_group_packer.sv
// Bench for lzrw_group_packer: a group/byte-queue model checked every cycle,
// plus literal byte tables for the directed scenarios.
module tb_lzrw_group_packer;
   localparam int GROUP = 16;

   logic        i_clock = 0, i_reset = 1;
   logic        i_item_valid = 0, i_item_is_copy = 0, i_flush = 0, i_out_ready = 1;
   logic [7:0]  i_item_literal = 0;
   logic [3:0]  i_item_length = 0;
   logic [11:0] i_item_offset = 0;
   logic        o_item_ready, o_out_valid, o_out_last, o_flush_done;
   logic [7:0]  o_out_data;
   logic [31:0] o_bytes_out, o_items_in;

   lzrw_group_packer dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_item_valid(i_item_valid),
      .o_item_ready(o_item_ready), .i_item_is_copy(i_item_is_copy),
      .i_item_literal(i_item_literal), .i_item_length(i_item_length),
      .i_item_offset(i_item_offset), .i_flush(i_flush), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
      .o_flush_done(o_flush_done), .o_bytes_out(o_bytes_out), .o_items_in(o_items_in));

   always #5 i_clock = ~i_clock;

   typedef struct {logic c; logic [7:0] lit; logic [3:0] len; logic [11:0] off;} item_t;
   typedef struct {logic [7:0] d; logic l;} byte_t;

   item_t grp[$];
   byte_t exp_q[$];
   byte_t cap[$];
   int    n_chk = 0, n_fail = 0;
   logic  m_done = 0, m_pend = 0;
   logic [31:0] m_bytes = 0, m_items = 0;
   logic  prev_stall = 0, prev_last = 0;
   logic [7:0] prev_data = 0;
   bit    rnd_ready = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Turn the collected group into its LZRW1 byte sequence
   task automatic finalize(input bit fl);
      logic [GROUP-1:0] cw;
      logic [15:0] w;
      byte_t t;
      cw = '0;
      foreach (grp[i]) cw[i] = grp[i].c;
      for (int k = 0; k < GROUP/8; k++) begin t.d = cw[k*8 +: 8]; t.l = 0; exp_q.push_back(t); end
      foreach (grp[i]) begin
         t.l = 0;
         if (grp[i].c) begin
            w = {grp[i].len, grp[i].off};
            t.d = w[15:8]; exp_q.push_back(t);
            t.d = w[7:0];  exp_q.push_back(t);
         end else begin
            t.d = grp[i].lit; exp_q.push_back(t);
         end
      end
      if (fl) begin t = exp_q.pop_back(); t.l = 1; exp_q.push_back(t); end
      grp.delete();
   endtask

   // Compare process: check first, then advance the model with this cycle's handshakes
   always @(negedge i_clock) begin
      if (i_reset) begin
         grp.delete(); exp_q.delete();
         m_done = 0; m_pend = 0; m_bytes = 0; m_items = 0; prev_stall = 0;
      end else begin
         chk("out_valid", o_out_valid, exp_q.size() != 0);
         chk("item_ready", o_item_ready, exp_q.size() == 0 && !m_done);
         chk("flush_done", o_flush_done, m_done);
         chk("bytes_out", o_bytes_out, m_bytes);
         chk("items_in", o_items_in, m_items);
         if (prev_stall) begin
            chk("stall_data", o_out_data, prev_data);
            chk("stall_last", o_out_last, prev_last);
         end
         if (o_out_valid && exp_q.size() != 0) begin
            chk("out_data", o_out_data, exp_q[0].d);
            chk("out_last", o_out_last, exp_q[0].l);
            if (i_out_ready) begin
               cap.push_back('{o_out_data, o_out_last});
               if (exp_q[0].l) m_done = 1;
               void'(exp_q.pop_front());
               m_bytes++;
            end
         end
         prev_stall = o_out_valid && !i_out_ready;
         prev_data  = o_out_data;
         prev_last  = o_out_last;
         if (exp_q.size() == 0 && !m_done && o_item_ready) begin
            logic fe;
            fe = i_flush | m_pend;
            if (i_item_valid) begin
               grp.push_back('{i_item_is_copy, i_item_literal, i_item_length, i_item_offset});
               m_items++;
            end
            if (grp.size() == GROUP) begin finalize(fe); m_pend = 0; end
            else if (fe) begin
               if (grp.size() > 0) finalize(1); else m_done = 1;
               m_pend = 0;
            end
         end else if (i_flush) m_pend = 1;
      end
   end

   always @(posedge i_clock) begin
      #1 i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic do_reset();
      @(posedge i_clock); #1 i_reset = 1;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 0;
      cap.delete();
   endtask

   task automatic send(input logic c, input logic [7:0] lit, input logic [3:0] len,
                       input logic [11:0] off, input logic fl);
      int n = 0;
      i_item_valid = 1; i_item_is_copy = c; i_item_literal = lit;
      i_item_length = len; i_item_offset = off; i_flush = fl;
      @(negedge i_clock);
      while (!o_item_ready && n < 2000) begin n++; @(negedge i_clock); end
      if (n >= 2000) chk("item_accept_timeout", 1, 0);
      @(posedge i_clock); #1;
      i_item_valid = 0; i_flush = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge i_clock); #1; n++; end
      while (!(exp_q.size() == 0 && (o_item_ready || o_flush_done)) && n < 4000);
      if (n >= 4000) chk("idle_timeout", 1, 0);
   endtask

   task automatic chk_cap(input string nm, input logic [7:0] tbl[], input int last_idx);
      chk({nm, "_len"}, cap.size(), tbl.size());
      foreach (tbl[i]) if (i < cap.size()) begin
         chk({nm, "_byte"}, cap[i].d, tbl[i]);
         chk({nm, "_last"}, cap[i].l, i == last_idx);
      end
      cap.delete();
   endtask

   initial begin
      logic [7:0] tbl[];
      int n, total;
      do_reset();
      // Idle after reset
      repeat (10) begin
         @(negedge i_clock); #1;
         chk("idle_valid", o_out_valid, 0);
         chk("idle_ready", o_item_ready, 1);
         chk("idle_bytes", o_bytes_out, 0);
         chk("idle_data", o_out_data, 0);
         chk("idle_done", o_flush_done, 0);
      end
      @(posedge i_clock); #1;

      // 16 literals 0x41..0x50
      for (int i = 0; i < 16; i++) send(0, 8'(8'h41 + i), 0, 0, 0);
      n = 0;
      @(negedge i_clock);
      while (!o_item_ready && n < 100) begin n++; @(negedge i_clock); end
      chk("ready_low_cycles", n, 18);
      tbl = new[18];
      tbl[0] = 8'h00; tbl[1] = 8'h00;
      for (int i = 0; i < 16; i++) tbl[2+i] = 8'(8'h41 + i);
      chk_cap("lit16", tbl, -1);
      chk("lit16_bytes_out", o_bytes_out, 18);
      chk("lit16_items_in", o_items_in, 16);
      @(posedge i_clock); #1;

      // Copy first then 15 literals
      send(1, 0, 4'd3, 12'h123, 0);
      for (int i = 1; i < 16; i++) send(0, 8'(8'h2F + i), 0, 0, 0);
      wait_idle();
      tbl = new[19];
      tbl[0] = 8'h01; tbl[1] = 8'h00; tbl[2] = 8'h31; tbl[3] = 8'h23;
      for (int i = 0; i < 15; i++) tbl[4+i] = 8'(8'h30 + i);
      chk_cap("copy0", tbl, -1);
      chk("copy0_bytes_out", o_bytes_out, 37);
      chk("copy0_items_in", o_items_in, 32);
      @(posedge i_clock); #1;

      // Four full groups under random back-pressure
      rnd_ready = 1; total = 0;
      for (int i = 0; i < 4*GROUP; i++) begin
         logic c;
         c = 1'($urandom_range(0, 1));
         total += c ? 2 : 1;
         send(c, 8'($urandom), 4'($urandom), 12'($urandom), 0);
      end
      wait_idle();
      rnd_ready = 0;
      chk("rand_total_bytes", cap.size(), total + 4*(GROUP/8));
      chk("rand_bytes_out", o_bytes_out, 37 + total + 4*(GROUP/8));

      // Reset in the middle of data emission
      do_reset();
      for (int i = 0; i < 16; i++) send(0, 8'(i), 0, 0, 0);
      repeat (5) @(posedge i_clock);
      #1 i_reset = 1;
      @(posedge i_clock); #1 i_reset = 0;
      @(negedge i_clock); #1;
      chk("rst_mid_valid", o_out_valid, 0);
      chk("rst_mid_ready", o_item_ready, 1);
      chk("rst_mid_bytes", o_bytes_out, 0);
      chk("rst_mid_items", o_items_in, 0);
      chk("rst_mid_data", o_out_data, 0);
      cap.delete();
      @(posedge i_clock); #1;

      // Partial group closed by flush on the last item
      send(0, 8'h61, 0, 0, 0);
      send(1, 0, 4'd5, 12'hABC, 0);
      send(0, 8'h62, 0, 0, 1);
      wait_idle();
      tbl = new[6];
      tbl[0] = 8'h02; tbl[1] = 8'h00; tbl[2] = 8'h61; tbl[3] = 8'h5A; tbl[4] = 8'hBC; tbl[5] = 8'h62;
      chk_cap("flush3", tbl, 5);
      repeat (3) begin
         chk("flush3_done", o_flush_done, 1);
         chk("flush3_ready", o_item_ready, 0);
         @(negedge i_clock); #1;
      end

      // Flush with nothing pending
      do_reset();
      i_flush = 1;
      @(posedge i_clock); #1 i_flush = 0;
      @(negedge i_clock); #1;
      chk("empty_flush_done", o_flush_done, 1);
      chk("empty_flush_valid", o_out_valid, 0);
      chk("empty_flush_last", o_out_last, 0);
      repeat (4) @(negedge i_clock);
      chk("empty_flush_nobytes", cap.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lzrw_group_packer.md
# lzrw_group_packer

Streaming, parametrised successor to the compressed-value collector in the LZRW1 compressor. It accepts one literal or copy item per handshake and groups items GROUP at a time behind a GROUP-bit control word. It serialises each group as an LZRW1-format byte stream (control bytes first, then item bytes) on a valid/ready byte port, instead of filling a whole-string array. It sits between the match/table stage and the output byte sink.

## Interface
- GROUP, 16, items per control word; multiple of 8, range 8..64
- LEN_W, 4, copy length field width
- OFFSET_W, 12, copy offset field width; LEN_W+OFFSET_W must be a multiple of 8 (COPY_BYTES = (LEN_W+OFFSET_W)/8)
- CNT_W, 32, width of statistics counters
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- item_valid  in  1  item present
- item_ready  out  1  packer can accept an item
- item_is_copy  in  1  1 = copy item, 0 = literal (becomes the control bit)
- item_literal  in  8  literal byte
- item_length  in  LEN_W  copy length
- item_offset  in  OFFSET_W  copy offset
- flush  in  1  end-of-string pulse; emit the partial group, then stop
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the byte
- out_data  out  8  output byte
- out_last  out  1  marks the final byte of the stream after flush
- flush_done  out  1  sticky; all bytes emitted after flush
- bytes_out  out  CNT_W  bytes transferred since reset
- items_in  out  CNT_W  items accepted since reset

## Operation
- Storage:
  - byte buffer of GROUP*COPY_BYTES entries
  - wr_ptr, rd_ptr, item_cnt counters
  - ctrl register, GROUP bits
  - flush_pend flag
- States: COLLECT, EMIT_CTRL, EMIT_DATA, DONE.
- COLLECT: item_ready=1. An item is accepted on item_valid&&item_ready:
  - ctrl[item_cnt] <= item_is_copy.
  - A literal writes 1 byte.
  - A copy writes COPY_BYTES bytes of {length,offset}, MSB byte first. With defaults: {len[3:0],off[11:8]}, then off[7:0].
  - item_cnt++ and items_in++.
- COLLECT -> EMIT_CTRL when the accepted item makes item_cnt==GROUP.
- COLLECT -> EMIT_CTRL on flush (or flush_pend) with item_cnt>0.
- COLLECT -> DONE on flush with item_cnt==0 and no item accepted that cycle. Nothing is emitted; out_last is never asserted.
- flush in the same cycle as an accepted item: the item is included in the final group.
- flush while not in COLLECT: latched into flush_pend and serviced at the next return to COLLECT.
- EMIT_CTRL: emits GROUP/8 bytes, LSB byte first (byte k = ctrl[8k+7:8k]). Bits for unfilled item slots are 0. Then goes to EMIT_DATA.
- EMIT_DATA: emits buffer[0..wr_ptr-1] in order.
- After the last data byte transfers:
  - if flushing: go to DONE;
  - otherwise: clear ctrl, wr_ptr, rd_ptr, item_cnt and go to COLLECT.
- out_last=1 only on the final data byte of a flushed group.
- DONE: item_ready=0, out_valid=0, flush_done=1. Held until reset.
- A byte transfers on out_valid&&out_ready, which increments bytes_out. While out_ready=0, out_data and out_last hold stable.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values (the cycle after reset is sampled high):
  - state=COLLECT, item_ready=1
  - out_valid=0, out_last=0, out_data=0
  - flush_done=0, flush_pend=0
  - counters, ctrl and pointers all 0
- Reset mid-emit abandons the group with no further bytes.
- item_ready and out_valid are decoded from the registered state. out_data is muxed from registered buffer/ctrl by rd index.
- The item that fills a group: out_valid=1 on the next cycle.
- Full group throughput with out_ready=1: GROUP/8 + wr_ptr cycles of emission, one byte per cycle. item_ready=0 throughout.
- After the final byte of a group: item_ready=1 on the next cycle.
- After the final flushed byte: flush_done=1 on the next cycle.
- Flush with an empty group: flush_done=1 on the next cycle.
- Items are never accepted in EMIT_CTRL, EMIT_DATA or DONE.

## Test plan
- Reset then idle: out_valid=0, item_ready=1, bytes_out=0 for 10 cycles. Assert reset mid EMIT_DATA: out_valid=0 the next cycle, pointers cleared.
- 16 literals 0x41..0x50, out_ready=1: 18 bytes 0x00,0x00,0x41..0x50; out_last=0; item_ready low 18 cycles; bytes_out=18, items_in=16.
- Item 0 copy (len 3, off 0x123), items 1..15 literals 0x30..0x3E: 0x01,0x00,0x31,0x23,0x30..0x3E (19 bytes).
- Literal 0x61, copy (len 5, off 0xABC), literal 0x62 issued with flush in the same cycle: 0x02,0x00,0x61,0x5A,0xBC,0x62. out_last on 0x62; flush_done=1 the next cycle; item_ready stays 0.
- Random out_ready (50%) over 4 full groups: byte sequence equals the golden model; data stable while stalled; no bytes dropped or duplicated.
- flush with 0 pending items: no out_valid; flush_done=1 the next cycle; out_last never asserted.
